// File: rtl/dmem_arbiter_if.sv
// Shared data-memory bus: core load/store port, debug/loader port and memory port.
// Handshake: c_req/d_req are levels held by the requester until the matching
// one-cycle c_done/d_ack pulse; rdata is valid in that pulse cycle.
interface dmem_arbiter_if;
  logic        c_req;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [2:0]  c_funct3;
  logic [31:0] c_rdata;
  logic        c_done;
  logic        c_stall;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;

  logic        m_we;
  logic        m_re;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_funct3;
  logic [31:0] m_rdata;

  // slave = the arbiter; master = requesters plus the memory.
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_funct3,
    output c_rdata, c_done, c_stall,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ack,
    output m_we, m_re, m_addr, m_wdata, m_funct3,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_funct3,
    input  c_rdata, c_done, c_stall,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ack,
    input  m_we, m_re, m_addr, m_wdata, m_funct3,
    output m_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin sequencer sharing one data-memory port between the core and a
// debug/loader port, with a fixed MEM_LAT-cycle access window per grant.
module dmem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  dmem_arbiter_if.slave    bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  state_t      state, state_d;
  logic        owner;
  logic        last;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic [1:0]  cnt;
  logic [31:0] c_rdata_q;
  logic [31:0] d_rdata_q;
  logic        grant;
  logic        grant_dbg;

  // On a tie the side that was not served last wins.
  always_comb begin
    state_d   = state;
    grant     = 1'b0;
    grant_dbg = 1'b0;
    case (state)
      IDLE: begin
        if (bus.c_req || bus.d_req) begin
          grant     = 1'b1;
          grant_dbg = bus.d_req & (~bus.c_req | ~last);
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == 2'd0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.m_we     = 1'b0;
    bus.m_re     = 1'b0;
    bus.m_addr   = 32'd0;
    bus.m_wdata  = 32'd0;
    bus.m_funct3 = 3'd0;
    if (state == ACCESS) begin
      bus.m_addr   = addr_q;
      bus.m_wdata  = wdata_q;
      bus.m_funct3 = funct3_q;
      // cnt only equals its load value in the first ACCESS cycle.
      bus.m_we     = we_q & (cnt == CNT_INIT);
      bus.m_re     = ~we_q;
    end
    bus.c_done  = (state == DONE) & ~owner;
    bus.d_ack   = (state == DONE) & owner;
    bus.c_stall = bus.c_req & ~bus.c_done;
    bus.c_rdata = c_rdata_q;
    bus.d_rdata = d_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      funct3_q  <= 3'd0;
      cnt       <= 2'd0;
      c_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      state <= state_d;
      if (state == IDLE && grant) begin
        owner <= grant_dbg;
        last  <= grant_dbg;
        cnt   <= CNT_INIT;
        if (grant_dbg) begin
          we_q     <= bus.d_we;
          addr_q   <= bus.d_addr;
          wdata_q  <= bus.d_wdata;
          funct3_q <= 3'b010;
        end else begin
          we_q     <= bus.c_we;
          addr_q   <= bus.c_addr;
          wdata_q  <= bus.c_wdata;
          funct3_q <= bus.c_funct3;
        end
      end else if (state == ACCESS) begin
        if (cnt != 2'd0) begin
          cnt <= cnt - 2'd1;
        end else if (!we_q) begin
          if (owner) d_rdata_q <= bus.m_rdata;
          else       c_rdata_q <= bus.m_rdata;
        end
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter at MEM_LAT = 1, 3 and 4 with a scoreboard
// that checks every done/ack pulse against queued expected responses.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [1:0]  sel = 2'd0;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic [2:0]  c_funct3 = '0;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;

  localparam int LATS [3] = '{1, 3, 4};

  logic        o_c_done [3], o_c_stall [3], o_d_ack [3], o_m_we [3], o_m_re [3];
  logic [31:0] o_c_rdata [3], o_d_rdata [3], o_m_addr [3], o_m_wdata [3];
  logic [2:0]  o_m_funct3 [3];
  logic [1:0]  o_state [3];

  logic [31:0] mem [64];
  logic [63:0] wr_vld = '0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEADBEEF;
      32'h40:  return 32'hCAFEF00D;
      default: return {a[15:0], 16'hA5A5};
    endcase
  endfunction

  dmem_arbiter_if bus_if [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus_if[g].c_req    = c_req & (sel == 2'(g));
    assign bus_if[g].c_we     = c_we;
    assign bus_if[g].c_addr   = c_addr;
    assign bus_if[g].c_wdata  = c_wdata;
    assign bus_if[g].c_funct3 = c_funct3;
    assign bus_if[g].d_req    = d_req & (sel == 2'(g));
    assign bus_if[g].d_we     = d_we;
    assign bus_if[g].d_addr   = d_addr;
    assign bus_if[g].d_wdata  = d_wdata;
    always_comb bus_if[g].m_rdata = wr_vld[bus_if[g].m_addr[7:2]] ?
                                    mem[bus_if[g].m_addr[7:2]] : dflt(bus_if[g].m_addr);
    assign o_c_done[g]   = bus_if[g].c_done;
    assign o_c_stall[g]  = bus_if[g].c_stall;
    assign o_d_ack[g]    = bus_if[g].d_ack;
    assign o_m_we[g]     = bus_if[g].m_we;
    assign o_m_re[g]     = bus_if[g].m_re;
    assign o_c_rdata[g]  = bus_if[g].c_rdata;
    assign o_d_rdata[g]  = bus_if[g].d_rdata;
    assign o_m_addr[g]   = bus_if[g].m_addr;
    assign o_m_wdata[g]  = bus_if[g].m_wdata;
    assign o_m_funct3[g] = bus_if[g].m_funct3;

    dmem_arbiter #(.MEM_LAT(LATS[g])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if[g]),
      .dbg_state (o_state[g])
    );
  end

  logic        s_c_done, s_c_stall, s_d_ack, s_m_we, s_m_re;
  logic [31:0] s_c_rdata, s_d_rdata, s_m_addr, s_m_wdata;
  logic [2:0]  s_m_funct3;
  logic [1:0]  s_state;
  always_comb begin
    s_c_done   = o_c_done[sel];
    s_c_stall  = o_c_stall[sel];
    s_d_ack    = o_d_ack[sel];
    s_m_we     = o_m_we[sel];
    s_m_re     = o_m_re[sel];
    s_c_rdata  = o_c_rdata[sel];
    s_d_rdata  = o_d_rdata[sel];
    s_m_addr   = o_m_addr[sel];
    s_m_wdata  = o_m_wdata[sel];
    s_m_funct3 = o_m_funct3[sel];
    s_state    = o_state[sel];
  end

  always @(posedge clk) begin
    if (s_m_we) begin
      mem[s_m_addr[7:2]]    <= s_m_wdata;
      wr_vld[s_m_addr[7:2]] <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q [$];
  logic [32:0] sb_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (s_c_done || s_d_ack)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=pulse(dbg=%0d) required=none", s_d_ack);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_resp", {31'd0, s_d_ack, (s_d_ack ? s_d_rdata : s_c_rdata)}, {31'd0, sb_e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; c_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic core_access(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] f3,
                             input logic [31:0] exp_rd, input int lat);
    int stall_n = 0, re_n = 0, we_n = 0, done_at = -1;
    bit bus_ok = 1'b1;
    exp_q.push_back({1'b0, exp_rd});
    @(negedge clk);
    c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; c_funct3 = f3;
    for (int i = 0; i < lat + 8 && done_at < 0; i++) begin
      #1;
      if (s_c_stall) stall_n++;
      if (s_m_re) re_n++;
      if (s_m_we) we_n++;
      if ((s_m_re || s_m_we) && (s_m_addr !== addr || s_m_funct3 !== f3 ||
                                 (we && s_m_wdata !== wdata))) bus_ok = 1'b0;
      if (s_c_done) done_at = i;
      else @(negedge clk);
    end
    @(posedge clk);
    #1 c_req = 1'b0;
    chk({tag, "_done_lat"}, 64'(done_at), 64'(lat + 1));
    chk({tag, "_stall_cycles"}, 64'(stall_n), 64'(lat + 1));
    chk({tag, "_re_cycles"}, 64'(re_n), we ? 64'd0 : 64'(lat));
    chk({tag, "_we_cycles"}, 64'(we_n), we ? 64'd1 : 64'd0);
    chk({tag, "_bus_fields"}, 64'(bus_ok), 64'd1);
  endtask

  task automatic dbg_access(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rd,
                            input bit drop, input int lat);
    int ack_at = -1, acc_n = 0;
    bit bus_ok = 1'b1;
    exp_q.push_back({1'b1, exp_rd});
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    for (int i = 0; i < lat + 8 && ack_at < 0; i++) begin
      #1;
      if (s_state == 2'd1) begin
        acc_n++;
        if (s_m_addr !== addr || s_m_funct3 !== 3'b010) bus_ok = 1'b0;
        if (drop) d_req = 1'b0;
      end
      if (s_d_ack) ack_at = i;
      else @(negedge clk);
    end
    @(posedge clk);
    #1 d_req = 1'b0;
    chk({tag, "_ack_lat"}, 64'(ack_at), 64'(lat + 1));
    chk({tag, "_access_cycles"}, 64'(acc_n), 64'(lat));
    chk({tag, "_bus_fields"}, 64'(bus_ok), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int done_n;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 64'(s_state), 64'd0);
    chk("rst_outputs", {55'd0, s_c_done, s_d_ack, s_c_stall, s_m_we, s_m_re, s_m_funct3, s_state}, 64'd0);
    chk("rst_m_addr_wdata", {s_m_addr, s_m_wdata}, 64'd0);
    chk("rst_rdata", {s_c_rdata, s_d_rdata}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // MEM_LAT = 1 core load
    sel = 2'd0;
    core_access("ld_lat1", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1);

    // MEM_LAT = 3: load, store (rdata kept), read back the store
    do_reset();
    sel = 2'd1;
    core_access("ld_lat3", 1'b0, 32'h40, 32'h0, 3'b010, 32'hCAFEF00D, 3);
    core_access("st_lat3", 1'b1, 32'h20, 32'h12345678, 3'b010, 32'hCAFEF00D, 3);
    #1 chk("st_keeps_c_rdata", 64'(s_c_rdata), 64'hCAFEF00D);
    core_access("rb_lat3", 1'b0, 32'h20, 32'h0, 3'b010, 32'h12345678, 3);

    // MEM_LAT = 1 contention: both held for 6 grants
    do_reset();
    sel = 2'd0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({1'b0, 32'hDEADBEEF});
      exp_q.push_back({1'b1, 32'hCAFEF00D});
    end
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_funct3 = 3'b010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    n = 0;
    for (int i = 0; i < 40 && n < 6; i++) begin
      #1;
      if (s_c_done || s_d_ack) begin
        chk("rr_owner", 64'(s_d_ack), 64'(n % 2));
        chk("rr_time", 64'(i), 64'(2 + 3 * n));
        n++;
      end
      @(negedge clk);
    end
    c_req = 1'b0; d_req = 1'b0;
    chk("rr_grants", 64'(n), 64'd6);

    // Debug read with request dropped mid-access, then write / read back
    dbg_access("dbg_rd_drop", 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b1, 1);
    #1 chk("dbg_keeps_c_rdata", 64'(s_c_rdata), 64'hDEADBEEF);
    dbg_access("dbg_wr", 1'b1, 32'h44, 32'hA1B2C3D4, 32'hCAFEF00D, 1'b0, 1);
    dbg_access("dbg_rb", 1'b0, 32'h44, 32'h0, 32'hA1B2C3D4, 1'b0, 1);

    // MEM_LAT = 4: reset during the second ACCESS cycle
    do_reset();
    sel = 2'd2;
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_funct3 = 3'b010;
    repeat (2) @(negedge clk);
    #1;
    chk("abort_pre_re", 64'(s_m_re), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {59'd0, s_m_re, s_m_we, s_c_done, s_state}, 64'd0);
    chk("abort_m_addr", 64'(s_m_addr), 64'd0);
    c_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (s_c_done) done_n++;
    end
    chk("abort_no_done", 64'(done_n), 64'd0);
    core_access("after_abort", 1'b0, 32'h40, 32'h0, 3'b010, 32'hCAFEF00D, 4);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencing arbiter that shares the single data-memory port between the core's load/store path and a debug/loader port. It serialises accesses, drives the memory control signals (`WE`, `RE`, address, write data, `funct3`) for a configurable memory latency, returns read data, and stalls the core while its access is pending or while the debug port owns the memory. It sits between the control unit/ALU outputs and the data memory in the top level.

## Interface
- `MEM_LAT`, 1: cycles from access issue to valid `m_rdata`; legal range 1..4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `c_req`  in  1  core load/store request (level); held until `c_done`.
- `c_we`  in  1  core access is a store (1) or load (0).
- `c_addr`  in  32  core byte address (ALU result).
- `c_wdata`  in  32  core store data.
- `c_funct3`  in  3  core access size/sign, forwarded to memory.
- `c_rdata`  out  32  core load data; valid when `c_done`.
- `c_done`  out  1  one-cycle pulse; the core access has completed.
- `c_stall`  out  1  freeze PC and register write-back.
- `d_req`  in  1  debug request (level); held until `d_ack`.
- `d_we`  in  1  debug write (1) or read (0).
- `d_addr`  in  32  debug byte address.
- `d_wdata`  in  32  debug write data; always a word access.
- `d_rdata`  out  32  debug read data; valid when `d_ack`.
- `d_ack`  out  1  one-cycle pulse; the debug access has completed.
- `m_we`  out  1  memory write enable.
- `m_re`  out  1  memory read enable.
- `m_addr`  out  32  memory address.
- `m_wdata`  out  32  memory write data.
- `m_funct3`  out  3  memory size code; 3'b010 for debug.
- `m_rdata`  in  32  memory read data.

## Operation
- States: IDLE, ACCESS, DONE. Registers: `owner` (0 = core, 1 = debug), `last` (the last owner), latched `we`/`addr`/`wdata`/`funct3`, down-counter `cnt` (2 bits), and the `c_rdata`/`d_rdata` holding registers.
- IDLE: with no request, remain in IDLE. With exactly one request, grant that requester. With both requesting, grant the requester that is not `last` (round-robin). On a grant, latch the request fields, set `owner` and `last`, load `cnt = MEM_LAT-1`, and go to ACCESS.
- ACCESS:
  - `m_addr`, `m_wdata` and `m_funct3` are driven from the latched fields.
  - For a write, `m_we = 1` only in the first ACCESS cycle. For a read, `m_re = 1` in every ACCESS cycle.
  - `cnt` decrements each cycle. When `cnt == 0`, capture `m_rdata` into the owner's rdata register (reads only) and go to DONE.
- DONE: pulse `c_done` or `d_ack` for the owner, then go to IDLE. The non-owner's rdata register is unchanged.
- `c_stall = c_req & ~c_done` (combinational).
- In IDLE and DONE, all `m_*` outputs are 0.
- Write data is never captured into an rdata register. A write leaves the owner's rdata register unchanged.
- Dropping a request during ACCESS has no effect: the access completes and the done/ack pulse still fires.
- A request raised during ACCESS or DONE is not seen until the next IDLE.

## Timing
- Reset values (asynchronous):
  - State = IDLE, `owner = 0`, `last = 1`, so the core wins the first tie.
  - `cnt = 0`.
  - All outputs are 0, including `c_rdata`, `d_rdata` and `c_stall` (when `c_req = 0`).
- Latency: a request sampled in IDLE at edge N gives ACCESS cycles N+1 .. N+MEM_LAT, the done/ack pulse in cycle N+MEM_LAT+1, and IDLE in cycle N+MEM_LAT+2. The minimum spacing between grants is MEM_LAT+2 cycles.
- A core access therefore stalls the core for MEM_LAT+1 cycles. The core advances on the edge that ends the `c_done` cycle.
- Contention: the loser waits one full access (MEM_LAT+2 cycles) and is guaranteed the next grant. No starvation is possible.
- Reset asserted mid-ACCESS:
  - The machine returns to IDLE immediately and no done/ack pulse is issued.
  - `m_we` deasserts asynchronously.
  - Memory contents written on a prior edge are kept.
- `MEM_LAT` values outside 1..4 are illegal. The block is not required to handle them.

## Test plan
- Reset with MEM_LAT=1, then a core load with `c_addr=0x10`, memory returning 0xDEADBEEF: `m_re` high for 1 cycle with `m_addr=0x10`; `c_done` 2 cycles after issue with `c_rdata=0xDEADBEEF`; `c_stall` high for exactly 2 cycles.
- Core store with MEM_LAT=3, `c_addr=0x20`, `c_wdata=0x12345678`, `c_funct3=3'b010`: `m_we` high for exactly 1 cycle and `m_re` never high; `c_done` 4 cycles after issue; `c_rdata` keeps its previous value.
- `c_req` and `d_req` rise in the same cycle after reset: the core is granted first, the debug access follows 3 cycles later (MEM_LAT=1), and `d_ack` arrives 5 cycles after the requests.
- Both requests held continuously for 6 grants: owners alternate core, debug, core, …, and neither side ever waits for more than one access.
- Debug read of address 0x40 with `d_req` dropped during ACCESS: `d_ack` still pulses, `d_rdata` is updated, and `m_funct3=3'b010`.
- `rst` asserted during the second ACCESS cycle at MEM_LAT=4: outputs go to 0 immediately, there is no `c_done`, and a fresh request after reset completes normally.
